// File: rtl/layer1_stream_out.sv
// ---------------------------------------------------------------------------
// layer1_stream_out
//
// Purpose:
//   Reads the 32x32 max-pooled layer-1 map back from the shared result
//   memory in raster order once the convolution engine reports completion.
//   The values are streamed out over a valid/ready interface through a small
//   prefetch FIFO. The unsigned maximum of the map is reported when done.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      one-cycle pulse: pooled map complete (ignored while busy)
//   busy       high from accepted start until the done pulse has passed
//   crd        result-memory read strobe
//   caddr_rd   result-memory read address
//   csel       memory select, CSEL_VAL while reads are being issued
//   cdata_rd   read data, valid the cycle after crd
//   out_valid  out_data/out_idx/out_last valid (FIFO non-empty)
//   out_ready  sink accepts the current head
//   out_data   pooled value at the FIFO head
//   out_idx    raster index (y*32+x) of out_data
//   out_last   head is the final element of the map
//   max_val    unsigned maximum of all values read, valid at done
//   done       one-cycle pulse the cycle after the last transfer
// ---------------------------------------------------------------------------
module layer1_stream_out #(
  parameter int         DW         = 20,
  parameter int         AW         = 12,
  parameter int         N_ELEM     = 1024,
  parameter int         BASE_ADDR  = 0,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] CSEL_VAL   = 3'b011
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  output logic [2:0]    csel,
  input  logic [DW-1:0] cdata_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [9:0]    out_idx,
  output logic          out_last,
  output logic [DW-1:0] max_val,
  output logic          done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int RW = $clog2(N_ELEM + 1);

  localparam logic [RW-1:0] N_ELEM_R  = RW'(N_ELEM);
  localparam logic [RW-1:0] LAST_RD   = RW'(N_ELEM - 1);
  localparam logic [9:0]    LAST_IDX  = 10'(N_ELEM - 1);
  localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] BASE_C    = AW'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rd_idx_q, rd_idx_d;     // reads issued so far
  logic [9:0]      wr_idx_q, wr_idx_d;     // raster index of the next push
  logic            pend_q;                 // cdata_rd carries read data this cycle
  logic            busy_q, busy_d;
  logic            crd_q, crd_d;
  logic [AW-1:0]   caddr_q, caddr_d;
  logic [2:0]      csel_q, csel_d;
  logic            done_q, done_d;
  logic [DW-1:0]   max_q, max_d;

  // Prefetch FIFO
  logic [DW-1:0]   val_mem [FIFO_DEPTH];
  logic [9:0]      idx_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            head_valid;
  logic            push;
  logic            pop;
  logic [CW:0]     occupancy;
  logic            credit;

  assign head_valid = (count_q != '0);
  assign out_valid  = head_valid;
  assign out_data   = head_valid ? val_mem[rd_ptr_q] : '0;
  assign out_idx    = head_valid ? idx_mem[rd_ptr_q] : '0;
  assign out_last   = head_valid && (idx_mem[rd_ptr_q] == LAST_IDX);

  assign busy     = busy_q;
  assign crd      = crd_q;
  assign caddr_rd = caddr_q;
  assign csel     = csel_q;
  assign done     = done_q;
  assign max_val  = max_q;

  always_comb begin
    push      = pend_q;
    pop       = head_valid && out_ready;

    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A read issued now lands in the FIFO two edges from now; by then the
    // entries already held plus the read on the bus this cycle (crd_q) must
    // leave room for it even if the sink takes nothing in between.
    occupancy = {1'b0, count_d} + {{CW{1'b0}}, crd_q};
    credit    = (occupancy < DEPTH_C);

    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    wr_idx_d  = wr_idx_q;
    busy_d    = busy_q;
    crd_d     = 1'b0;
    caddr_d   = caddr_q;
    csel_d    = csel_q;
    done_d    = 1'b0;
    max_d     = max_q;

    if (push) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (cdata_rd > max_q) begin
        max_d = cdata_rd;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // The first read is issued on the accepting edge so crd rises
          // in the cycle straight after start.
          busy_d   = 1'b1;
          max_d    = '0;
          wr_idx_d = '0;
          crd_d    = 1'b1;
          caddr_d  = BASE_C;
          csel_d   = CSEL_VAL;
          rd_idx_d = RW'(1);
          state_d  = (N_ELEM == 1) ? S_DRAIN : S_FETCH;
        end
      end
      S_FETCH: begin
        if (credit && (rd_idx_q < N_ELEM_R)) begin
          crd_d    = 1'b1;
          caddr_d  = BASE_C + AW'(rd_idx_q);
          csel_d   = CSEL_VAL;
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == LAST_RD) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        csel_d = 3'b000;
        // The last element can only leave the FIFO here, since its read is
        // issued on the edge that enters this state.
        if (pop && out_last) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      crd_q    <= 1'b0;
      caddr_q  <= '0;
      csel_q   <= 3'b000;
      done_q   <= 1'b0;
      max_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      pend_q   <= crd_q;
      busy_q   <= busy_d;
      crd_q    <= crd_d;
      caddr_q  <= caddr_d;
      csel_q   <= csel_d;
      done_q   <= done_d;
      max_q    <= max_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      val_mem[wr_ptr_q] <= cdata_rd;
      idx_mem[wr_ptr_q] <= wr_idx_q;
    end
  end

endmodule

// File: tb/tb_layer1_stream_out.sv
// ---------------------------------------------------------------------------
// tb_layer1_stream_out
//
// Purpose:
//   Self-checking bench for layer1_stream_out. A behavioural result memory
//   answers reads one cycle later; the expected stream is simply the memory
//   image in raster order and the expected maximum is its software maximum.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_layer1_stream_out;

  localparam int DW = 20;
  localparam int AW = 12;
  localparam int N  = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [2:0]    csel;
  logic [DW-1:0] cdata_rd = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [9:0]    out_idx;
  logic          out_last;
  logic [DW-1:0] max_val;
  logic          done;

  always #5 clk = ~clk;

  layer1_stream_out #(
    .DW(DW), .AW(AW), .N_ELEM(N), .BASE_ADDR(0), .FIFO_DEPTH(4), .CSEL_VAL(3'b011)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .crd(crd),
    .caddr_rd(caddr_rd), .csel(csel), .cdata_rd(cdata_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .max_val(max_val), .done(done)
  );

  // Result memory: data appears the cycle after the strobe.
  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) begin
    if (crd) cdata_rd <= mem[caddr_rd];
  end

  logic [DW-1:0] img [N];

  int compared   = 0;
  int mismatched = 0;

  // Observations collected by run_stream
  logic [DW-1:0] got_data [N];
  logic [9:0]    got_idx  [N];
  logic          got_last [N];
  int ntrans, nreads, first_valid, done_cnt, done_cyc, last_cyc;
  int busy_at1, busy_after, max_at_done, max_out, addr_err, hold_err;
  int reads_at_hold, data_at_hold, valid_at_hold;

  task automatic load_image();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < N; i++) mem[i] = img[i];
  endtask

  function automatic int sw_max();
    int m = 0;
    for (int i = 0; i < N; i++) if (int'(img[i]) > m) m = int'(img[i]);
    return m;
  endfunction

  // Pulses start and records what the DUT does cycle by cycle (sampled on
  // the falling edge). No checking happens here.
  task automatic run_stream(input int pct, input int hold0, input int restart_at,
                            input int stop_at);
    logic          stalled = 1'b0;
    logic [DW-1:0] pdata = '0;
    logic [9:0]    pidx = '0;
    logic          plast = 1'b0;
    bit            restarted = 0;
    ntrans = 0; nreads = 0; first_valid = -1; done_cnt = 0; done_cyc = -1;
    last_cyc = -1; busy_at1 = -1; busy_after = -1; max_at_done = -1;
    max_out = 0; addr_err = 0; hold_err = 0; reads_at_hold = -1;
    data_at_hold = -1; valid_at_hold = -1;
    for (int i = 0; i < N; i++) begin
      got_data[i] = 'x; got_idx[i] = 'x; got_last[i] = 1'bx;
    end
    @(negedge clk);
    start = 1'b1;
    out_ready = (hold0 > 0) ? 1'b0 : 1'b1;
    for (int cyc = 1; cyc < 8000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (crd) begin
        if (caddr_rd !== AW'(nreads) || csel !== 3'b011) addr_err++;
        nreads++;
      end
      if (nreads - ntrans > max_out) max_out = nreads - ntrans;
      if (cyc == 1) busy_at1 = int'(busy);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          max_at_done = int'(max_val);
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = int'(busy);
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (stalled && (!out_valid || out_data !== pdata || out_idx !== pidx ||
                      out_last !== plast)) hold_err++;
      if (cyc == hold0 - 1) begin
        reads_at_hold = nreads;
        data_at_hold  = int'(out_data);
        valid_at_hold = int'(out_valid);
      end
      if (stop_at >= 0 && ntrans == stop_at) return;
      if (restart_at >= 0 && ntrans == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      out_ready = (cyc < hold0) ? 1'b0 : (int'($urandom_range(0, 99)) < pct);
      if (out_valid && out_ready) begin
        if (ntrans < N) begin
          got_data[ntrans] = out_data;
          got_idx[ntrans]  = out_idx;
          got_last[ntrans] = out_last;
        end
        if (out_last) last_cyc = cyc;
        ntrans++;
      end
      stalled = out_valid && !out_ready;
      pdata = out_data; pidx = out_idx; plast = out_last;
      if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
    end
    start = 1'b0;
    $display("run: pct=%0d transfers=%0d reads=%0d done_pulses=%0d max_val=%0h",
             pct, ntrans, nreads, done_cnt, max_at_done);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    compared += 10;
    if (busy !== 1'b0)      begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
    if (crd !== 1'b0)       begin mismatched++; $display("FAIL reset_crd got %b want 0", crd); end
    if (caddr_rd !== '0)    begin mismatched++; $display("FAIL reset_caddr got %0h want 0", caddr_rd); end
    if (csel !== 3'b000)    begin mismatched++; $display("FAIL reset_csel got %b want 000", csel); end
    if (done !== 1'b0)      begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
    if (max_val !== '0)     begin mismatched++; $display("FAIL reset_max got %0h want 0", max_val); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", out_valid); end
    if (out_data !== '0)    begin mismatched++; $display("FAIL reset_data got %0h want 0", out_data); end
    if (out_idx !== '0)     begin mismatched++; $display("FAIL reset_idx got %0d want 0", out_idx); end
    if (out_last !== 1'b0)  begin mismatched++; $display("FAIL reset_last got %b want 0", out_last); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_linear();
    for (int i = 0; i < N; i++) img[i] = DW'(i);
    load_image();
    run_stream(100, 0, -1, -1);
    compared += 8;
    if (ntrans !== N)             begin mismatched++; $display("FAIL lin_count got %0d want %0d", ntrans, N); end
    if (first_valid !== 3)        begin mismatched++; $display("FAIL lin_first_valid got %0d want 3", first_valid); end
    if (busy_at1 !== 1)           begin mismatched++; $display("FAIL lin_busy got %0d want 1", busy_at1); end
    if (done_cnt !== 1)           begin mismatched++; $display("FAIL lin_done_cnt got %0d want 1", done_cnt); end
    if (done_cyc !== last_cyc + 1) begin mismatched++; $display("FAIL lin_done_cyc got %0d want %0d", done_cyc, last_cyc + 1); end
    if (max_at_done !== N - 1)    begin mismatched++; $display("FAIL lin_max got %0d want %0d", max_at_done, N - 1); end
    if (busy_after !== 0)         begin mismatched++; $display("FAIL lin_busy_end got %0d want 0", busy_after); end
    if (addr_err !== 0)           begin mismatched++; $display("FAIL lin_addr got %0d bad reads want 0", addr_err); end
    for (int i = 0; i < N; i++) begin
      compared++;
      if (got_data[i] !== img[i] || got_idx[i] !== 10'(i) || got_last[i] !== (i == N - 1)) begin
        mismatched++;
        $display("FAIL lin_elem[%0d] got data=%0h idx=%0d last=%b want data=%0h idx=%0d last=%b",
                 i, got_data[i], got_idx[i], got_last[i], img[i], i, (i == N - 1));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < N; i++) img[i] = DW'(i);
    load_image();
    run_stream(100, 20, -1, -1);
    compared += 6;
    if (reads_at_hold !== 4) begin mismatched++; $display("FAIL stall_reads got %0d want 4", reads_at_hold); end
    if (valid_at_hold !== 1) begin mismatched++; $display("FAIL stall_valid got %0d want 1", valid_at_hold); end
    if (data_at_hold !== 0)  begin mismatched++; $display("FAIL stall_data got %0h want 0", data_at_hold); end
    if (hold_err !== 0)      begin mismatched++; $display("FAIL stall_hold got %0d changes want 0", hold_err); end
    if (ntrans !== N)        begin mismatched++; $display("FAIL stall_count got %0d want %0d", ntrans, N); end
    if (done_cnt !== 1)      begin mismatched++; $display("FAIL stall_done got %0d want 1", done_cnt); end
    for (int i = 0; i < N; i++) begin
      compared++;
      if (got_data[i] !== img[i] || got_idx[i] !== 10'(i)) begin
        mismatched++;
        $display("FAIL stall_elem[%0d] got data=%0h idx=%0d want data=%0h idx=%0d",
                 i, got_data[i], got_idx[i], img[i], i);
      end
    end
  endtask

  task automatic test_random_ready();
    int m;
    for (int i = 0; i < N; i++) img[i] = DW'($urandom);
    load_image();
    m = sw_max();
    run_stream(50, 0, -1, -1);
    compared += 5;
    if (ntrans !== N)     begin mismatched++; $display("FAIL rnd_count got %0d want %0d", ntrans, N); end
    if (max_at_done !== m) begin mismatched++; $display("FAIL rnd_max got %0h want %0h", max_at_done, m); end
    if (max_out > 4)      begin mismatched++; $display("FAIL rnd_occupancy got %0d want <=4", max_out); end
    if (hold_err !== 0)   begin mismatched++; $display("FAIL rnd_hold got %0d changes want 0", hold_err); end
    if (done_cnt !== 1)   begin mismatched++; $display("FAIL rnd_done got %0d want 1", done_cnt); end
    for (int i = 0; i < N; i++) begin
      compared++;
      if (got_data[i] !== img[i] || got_idx[i] !== 10'(i) || got_last[i] !== (i == N - 1)) begin
        mismatched++;
        $display("FAIL rnd_elem[%0d] got data=%0h idx=%0d last=%b want data=%0h idx=%0d",
                 i, got_data[i], got_idx[i], got_last[i], img[i], i);
      end
    end
  endtask

  task automatic test_restart();
    for (int i = 0; i < N; i++) img[i] = DW'($urandom);
    load_image();
    run_stream(100, 0, 100, -1);
    compared += 3;
    if (ntrans !== N)   begin mismatched++; $display("FAIL rst_busy_count got %0d want %0d", ntrans, N); end
    if (done_cnt !== 1) begin mismatched++; $display("FAIL rst_busy_done got %0d want 1", done_cnt); end
    if (addr_err !== 0) begin mismatched++; $display("FAIL rst_busy_addr got %0d bad reads want 0", addr_err); end
    for (int i = 0; i < N; i++) begin
      compared++;
      if (got_data[i] !== img[i] || got_idx[i] !== 10'(i)) begin
        mismatched++;
        $display("FAIL rst_busy_elem[%0d] got data=%0h idx=%0d want data=%0h idx=%0d",
                 i, got_data[i], got_idx[i], img[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) img[i] = DW'($urandom);
    load_image();
    run_stream(100, 0, -1, 500);
    compared += 6;
    if (ntrans !== 500) begin mismatched++; $display("FAIL mid_reached got %0d want 500", ntrans); end
    if (crd !== 1'b1)   begin mismatched++; $display("FAIL mid_inflight got crd=%b want 1", crd); end
    reset = 1'b1;
    @(negedge clk);
    if (busy !== 1'b0)      begin mismatched++; $display("FAIL mid_busy got %b want 0", busy); end
    if (crd !== 1'b0)       begin mismatched++; $display("FAIL mid_crd got %b want 0", crd); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_valid got %b want 0", out_valid); end
    if (max_val !== '0)     begin mismatched++; $display("FAIL mid_max got %0h want 0", max_val); end
    reset = 1'b0;
    @(negedge clk);
    run_stream(100, 0, -1, -1);
    compared += 3;
    if (ntrans !== N)      begin mismatched++; $display("FAIL mid_rerun_count got %0d want %0d", ntrans, N); end
    if (first_valid !== 3) begin mismatched++; $display("FAIL mid_rerun_first got %0d want 3", first_valid); end
    if (done_cnt !== 1)    begin mismatched++; $display("FAIL mid_rerun_done got %0d want 1", done_cnt); end
    for (int i = 0; i < N; i++) begin
      compared++;
      if (got_data[i] !== img[i] || got_idx[i] !== 10'(i)) begin
        mismatched++;
        $display("FAIL mid_elem[%0d] got data=%0h idx=%0d want data=%0h idx=%0d",
                 i, got_data[i], got_idx[i], img[i], i);
      end
    end
  endtask

  task automatic test_max_boundary();
    for (int i = 0; i < N; i++) img[i] = DW'($urandom_range(0, 32'h0FFFF));
    img[700] = 20'hFFFFF;
    load_image();
    run_stream(70, 0, -1, -1);
    compared += 3;
    if (max_at_done !== 32'hFFFFF) begin mismatched++; $display("FAIL max_top got %0h want fffff", max_at_done); end
    if (ntrans !== N)              begin mismatched++; $display("FAIL max_count got %0d want %0d", ntrans, N); end
    if (got_data[700] !== 20'hFFFFF) begin mismatched++; $display("FAIL max_elem700 got %0h want fffff", got_data[700]); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    test_reset();
    test_linear();
    test_stall();
    test_random_ready();
    test_restart();
    test_reset_mid();
    test_max_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
